// File: rtl/mem_arbiter_if.sv
// Bundle between mem_arbiter and its two cache controllers plus the DRAM model.
// master: the arbiter side; slave: the caches and DRAM.
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] mem_data;
  logic        mem_data_valid;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic        i_grant;
  logic        d_grant;
  logic        i_fill_valid;
  logic        d_fill_valid;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_done;
  logic        d_done;
  logic        busy;

  modport master (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data, mem_data_valid,
    output mem_addr, mem_en, mem_wr, mem_wdata, i_grant, d_grant,
           i_fill_valid, d_fill_valid, fill_word, fill_data, i_done, d_done, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_data, mem_data_valid,
    input  mem_addr, mem_en, mem_wr, mem_wdata, i_grant, d_grant,
           i_fill_valid, d_fill_valid, fill_word, fill_data, i_done, d_done, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter between I-cache and D-cache miss paths.
// Optional macro ARB_DPRIORITY_EN: D wins every simultaneous request
// (round-robin pointer removed). Undefined: round-robin on ties.
//
// state | meaning
// IDLE  | no side owns the port, arbitrate on i_req/d_req
// ISSUE | drive the eight block addresses, count returns
// DRAIN | all addresses issued, wait for remaining returns
// WRITE | single-word D-side store on the memory port
// DONE  | one-cycle completion pulse to the owner
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.master bus
);

  localparam logic [2:0] LAST_WORD = 3'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

  state_t      state, state_next;
  logic        owner_d, owner_next;
  logic [2:0]  issue_cnt, issue_next;
  logic [2:0]  ret_cnt, ret_next;
  logic [15:0] base_q, base_next;
  logic [15:0] mem_addr_q, mem_addr_next;
  logic        mem_en_q, mem_en_next;
  logic        mem_wr_q, mem_wr_next;
  logic [15:0] mem_wdata_q, mem_wdata_next;
  logic        tie_pick_d;
  logic        win_d;
  logic        ret_fire;

`ifdef ARB_DPRIORITY_EN
  assign tie_pick_d = 1'b1;
`else
  logic last_d;

  // Round-robin pointer: remembers who finished last, updated in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n)
      last_d <= 1'b0;
    else if (state == DONE)
      last_d <= owner_d;
  end

  assign tie_pick_d = ~last_d;
`endif

  // A returned word only counts while a fill owns the port; stale or
  // spurious valids in any other state are dropped here.
  assign ret_fire = bus.mem_data_valid && ((state == ISSUE) || (state == DRAIN));

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_next     = state;
    owner_next     = owner_d;
    issue_next     = issue_cnt;
    ret_next       = ret_cnt;
    base_next      = base_q;
    mem_addr_next  = 16'd0;
    mem_en_next    = 1'b0;
    mem_wr_next    = 1'b0;
    mem_wdata_next = 16'd0;
    win_d          = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          win_d      = bus.d_req && (!bus.i_req || tie_pick_d);
          owner_next = win_d;
          issue_next = 3'd0;
          ret_next   = 3'd0;
          mem_en_next = 1'b1;
          if (win_d && bus.d_wr) begin
            state_next     = WRITE;
            mem_wr_next    = 1'b1;
            mem_addr_next  = bus.d_addr;
            mem_wdata_next = bus.d_wdata;
          end else begin
            state_next    = ISSUE;
            base_next     = (win_d ? bus.d_addr : bus.i_addr) & 16'hFFF0;
            mem_addr_next = base_next;
          end
        end
      end
      ISSUE: begin
        if (ret_fire)
          ret_next = ret_cnt + 3'd1;
        if (ret_fire && (ret_cnt == LAST_WORD)) begin
          state_next = DONE;
        end else if (issue_cnt == LAST_WORD) begin
          state_next = DRAIN;
        end else begin
          issue_next    = issue_cnt + 3'd1;
          mem_en_next   = 1'b1;
          mem_addr_next = base_q | {12'd0, issue_next, 1'b0};
        end
      end
      DRAIN: begin
        if (ret_fire) begin
          ret_next = ret_cnt + 3'd1;
          if (ret_cnt == LAST_WORD)
            state_next = DONE;
        end
      end
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, counters and the registered memory-port drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      issue_cnt   <= 3'd0;
      ret_cnt     <= 3'd0;
      base_q      <= 16'd0;
      mem_addr_q  <= 16'd0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= 16'd0;
    end else begin
      state       <= state_next;
      owner_d     <= owner_next;
      issue_cnt   <= issue_next;
      ret_cnt     <= ret_next;
      base_q      <= base_next;
      mem_addr_q  <= mem_addr_next;
      mem_en_q    <= mem_en_next;
      mem_wr_q    <= mem_wr_next;
      mem_wdata_q <= mem_wdata_next;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.busy    = (state != IDLE);
  assign bus.i_grant = bus.busy && !owner_d;
  assign bus.d_grant = bus.busy && owner_d;

  assign bus.i_fill_valid = ret_fire && !owner_d;
  assign bus.d_fill_valid = ret_fire && owner_d;
  assign bus.fill_word    = ret_fire ? ret_cnt : 3'd0;
  assign bus.fill_data    = ret_fire ? bus.mem_data : 16'd0;

  assign bus.i_done = (state == DONE) && !owner_d;
  assign bus.d_done = (state == DONE) && owner_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory
// accesses, fill words, grants and dones; a negedge monitor pops and
// compares whenever the DUT presents one. DRAM model has 4-cycle latency
// and returns addr ^ 16'h5A5A.
module tb_mem_arbiter;

  typedef struct { int cyc; logic [15:0] addr; logic wr; logic [15:0] wdata; } mem_exp_t;
  typedef struct { int cyc; logic side; logic [2:0] word; logic [15:0] data; } fill_exp_t;
  typedef struct { int cyc; logic side; } ev_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  mem_exp_t  mem_q[$];
  fill_exp_t fill_q[$];
  ev_exp_t   done_q[$];
  ev_exp_t   grant_q[$];

  logic       pipe_v[4];
  logic [15:0] pipe_a[4];
  logic       iss_v;
  logic [15:0] iss_a;
  logic [1:0] gprev = 2'b00;

  mem_arbiter_if bus();

  mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] outs();
    return {4'd0, bus.mem_addr, bus.mem_en, bus.mem_wr, bus.mem_wdata, bus.i_grant,
            bus.d_grant, bus.i_fill_valid, bus.d_fill_valid, bus.fill_word,
            bus.fill_data, bus.i_done, bus.d_done, bus.busy};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic exp_fill(input logic side, input logic [15:0] addr, input int c);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    grant_q.push_back('{c + 1, side});
    for (int k = 0; k < 8; k++) begin
      mem_q.push_back('{c + 1 + k, base + 16'(2 * k), 1'b0, 16'd0});
      fill_q.push_back('{c + 5 + k, side, 3'(k), (base + 16'(2 * k)) ^ 16'h5A5A});
    end
    done_q.push_back('{c + 13, side});
  endtask

  task automatic exp_write(input logic [15:0] addr, input logic [15:0] data, input int c);
    grant_q.push_back('{c + 1, 1'b1});
    mem_q.push_back('{c + 1, addr, 1'b1, data});
    done_q.push_back('{c + 2, 1'b1});
  endtask

  // DRAM model: sample issued reads mid-cycle, return them four cycles later.
  always @(negedge clk) begin
    iss_v = bus.mem_en && !bus.mem_wr;
    iss_a = bus.mem_addr;
  end

  always @(posedge clk) begin
    #1;
    for (int s = 3; s > 0; s--) begin
      pipe_v[s] = pipe_v[s-1];
      pipe_a[s] = pipe_a[s-1];
    end
    pipe_v[0] = iss_v;
    pipe_a[0] = iss_a;
    bus.mem_data_valid = pipe_v[3];
    bus.mem_data       = pipe_v[3] ? (pipe_a[3] ^ 16'h5A5A) : 16'd0;
  end

  // Monitor: pop and compare whenever the DUT presents an event.
  always @(negedge clk) begin
    mem_exp_t  me;
    fill_exp_t fe;
    ev_exp_t   ee;
    logic [1:0] gv;
    if (bus.mem_en) begin
      if (mem_q.size() == 0) chk("mem_unexpected", {48'd0, bus.mem_addr}, 64'hFFFF_FFFF);
      else begin
        me = mem_q.pop_front();
        chk("mem_cycle", 64'(cyc), 64'(me.cyc));
        chk("mem_addr", {48'd0, bus.mem_addr}, {48'd0, me.addr});
        chk("mem_wr_wdata", {47'd0, bus.mem_wr, bus.mem_wdata}, {47'd0, me.wr, me.wdata});
      end
    end
    if (bus.i_fill_valid || bus.d_fill_valid) begin
      if (fill_q.size() == 0) chk("fill_unexpected", {63'd0, bus.d_fill_valid}, 64'hFFFF_FFFF);
      else begin
        fe = fill_q.pop_front();
        chk("fill_cycle", 64'(cyc), 64'(fe.cyc));
        chk("fill_side", {62'd0, bus.d_fill_valid, bus.i_fill_valid}, {62'd0, fe.side, !fe.side});
        chk("fill_word", {61'd0, bus.fill_word}, {61'd0, fe.word});
        chk("fill_data", {48'd0, bus.fill_data}, {48'd0, fe.data});
      end
    end
    if (bus.i_done || bus.d_done) begin
      if (done_q.size() == 0) chk("done_unexpected", {63'd0, bus.d_done}, 64'hFFFF_FFFF);
      else begin
        ee = done_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(ee.cyc));
        chk("done_side", {62'd0, bus.d_done, bus.i_done}, {62'd0, ee.side, !ee.side});
      end
    end
    gv = {bus.d_grant, bus.i_grant};
    if (gv == 2'b11) chk("grant_onehot", {62'd0, gv}, 64'd0);
    if (gv != gprev && gv != 2'b00) begin
      if (grant_q.size() == 0) chk("grant_unexpected", {62'd0, gv}, 64'hFFFF_FFFF);
      else begin
        ee = grant_q.pop_front();
        chk("grant_cycle", 64'(cyc), 64'(ee.cyc));
        chk("grant_side", {62'd0, gv}, {62'd0, ee.side, !ee.side});
      end
    end
    gprev = gv;
  end

  initial begin
    int c;
    for (int s = 0; s < 4; s++) begin
      pipe_v[s] = 1'b0;
      pipe_a[s] = 16'd0;
    end
    iss_v = 1'b0;
    iss_a = 16'd0;
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = 16'd0; bus.d_req = 1'b0; bus.d_wr = 1'b0;
    bus.d_addr = 16'd0; bus.d_wdata = 16'd0; bus.mem_data = 16'd0; bus.mem_data_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), 64'd0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // Simultaneous requests held: first tie goes to D, then alternate
    c = cyc;
    bus.i_req = 1'b1; bus.i_addr = 16'h2000;
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0010; bus.d_wdata = 16'h1111;
`ifdef ARB_DPRIORITY_EN
    exp_write(16'h0010, 16'h1111, c);
    exp_write(16'h0010, 16'h1111, c + 3);
    exp_write(16'h0010, 16'h1111, c + 6);
    step(9);
`else
    exp_write(16'h0010, 16'h1111, c);
    exp_fill(1'b0, 16'h2000, c + 3);
    exp_write(16'h0010, 16'h1111, c + 17);
    step(20);
`endif
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_wr = 1'b0;
    step(3);

    // Single I-fill
    c = cyc;
    bus.i_req = 1'b1; bus.i_addr = 16'h1236;
    exp_fill(1'b0, 16'h1236, c);
    step(14);
    bus.i_req = 1'b0;
    step(3);

    // D write-through
    c = cyc;
    bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 16'h0402; bus.d_wdata = 16'hBEEF;
    exp_write(16'h0402, 16'hBEEF, c);
    step(3);
    bus.d_req = 1'b0; bus.d_wr = 1'b0;
    step(3);

    // Contention: I requests during a D fill
    c = cyc;
    bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_addr = 16'h4321;
    exp_fill(1'b1, 16'h4321, c);
    exp_fill(1'b0, 16'h0100, c + 14);
    step(3);
    bus.i_req = 1'b1; bus.i_addr = 16'h0100;
    step(11);
    bus.d_req = 1'b0;
    step(14);
    bus.i_req = 1'b0;
    step(3);

    // Spurious valid in IDLE
    bus.mem_data_valid = 1'b1; bus.mem_data = 16'hDEAD;
    @(negedge clk);
    chk("spurious_fill_valid", {62'd0, bus.i_fill_valid, bus.d_fill_valid}, 64'd0);
    chk("spurious_busy", {63'd0, bus.busy}, 64'd0);
    step(1);
    @(negedge clk);
    chk("spurious_next_busy", {63'd0, bus.busy}, 64'd0);
    step(2);

    // Reset after the 3rd returned word of an I-fill
    c = cyc;
    bus.i_req = 1'b1; bus.i_addr = 16'h7008;
    grant_q.push_back('{c + 1, 1'b0});
    for (int k = 0; k < 8; k++)
      mem_q.push_back('{c + 1 + k, 16'h7000 + 16'(2 * k), 1'b0, 16'd0});
    for (int k = 0; k < 4; k++)
      fill_q.push_back('{c + 5 + k, 1'b0, 3'(k), (16'h7000 + 16'(2 * k)) ^ 16'h5A5A});
    step(8);
    rst_n = 1'b0; bus.i_req = 1'b0;
    step(1);
    @(negedge clk);
    chk("reset_mid_fill_outputs", outs(), 64'd0);
    step(1);
    rst_n = 1'b1;
    step(8);

    chk("mem_queue_empty", 64'(mem_q.size()), 64'd0);
    chk("fill_queue_empty", 64'(fill_q.size()), 64'd0);
    chk("done_queue_empty", 64'(done_q.size()), 64'd0);
    chk("grant_queue_empty", 64'(grant_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single off-chip main-memory port between the I-cache and D-cache miss paths. Each cache's controller raises a request. The arbiter grants one side and sequences the memory port for it:
- for a fill, it issues eight block-aligned word addresses and routes the returning words back to the owner;
- for a D-side write-through store, it issues a single memory write.

It sits between both cache controllers and the DRAM model and is the only driver of the memory address, enable and write lines.

## Interface
Parameters:
- BLOCK_WORDS, 8, words per cache block; fixed at 8, so word offset is addr[3:1].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- i_req  in  1  I-cache fill request; held high until i_done.
- i_addr  in  16  I-cache miss address; stable while i_req is high.
- d_req  in  1  D-cache request; held high until d_done.
- d_wr  in  1  qualifies d_req: 1 = single-word write, 0 = block fill.
- d_addr  in  16  D-side miss or store address.
- d_wdata  in  16  store data, valid when d_req and d_wr are high.
- mem_data  in  16  read data from DRAM.
- mem_data_valid  in  1  mem_data carries a returned read word.
- mem_addr  out  16  DRAM address.
- mem_en  out  1  DRAM access strobe.
- mem_wr  out  1  DRAM write enable; only valid with mem_en.
- mem_wdata  out  16  DRAM write data.
- i_grant, d_grant  out  1 each  side owning the port; one-hot or zero.
- i_fill_valid, d_fill_valid  out  1 each  fill word presented to the owner.
- fill_word  out  3  word index of fill_data within the block.
- fill_data  out  16  returned word, passed through from mem_data.
- i_done, d_done  out  1 each  one-cycle transaction-complete pulse.
- busy  out  1  FSM not in IDLE.

## Operation
States:
- **IDLE:** no side owns the port.
- **ISSUE:** sends the eight fill addresses while counting returns.
- **DRAIN:** waits for the remaining returns.
- **WRITE:** performs the single-word store.
- **DONE:** signals completion.

Arbitration (IDLE only, on the sampled i_req/d_req):
- One request high: that side wins.
- Both high: round-robin; the side not granted last wins.
- The last-grant pointer resets to "I", so the first tie goes to D.
- Winner D with d_wr=1: go to WRITE. Any other winner: go to ISSUE.

Fills:
- Base address = {addr[15:4], 4'b0000}.
- ISSUE drives mem_en=1, mem_wr=0, mem_addr = base + 2*k for k = 0..7 (3-bit issue counter), one address per cycle.
- After k=7, go to DRAIN unless all eight returns have already arrived.
- Returns are counted by a 3-bit return counter, independent of the issue counter.
  - Each mem_data_valid while owning a fill raises the owner's *_fill_valid for that cycle.
  - fill_word = return counter; fill_data = mem_data.
  - The counter then increments.
- After the 8th valid, go to DONE.
- DRAM returns words in issue order; the arbiter does not depend on DRAM latency.

Writes:
- WRITE lasts one cycle: mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata. Then go to DONE.

DONE:
- Lasts one cycle.
- The owner's *_done is 1 and its grant stays high.
- The last-grant pointer updates to the owner.
- Next state is IDLE.

Requester contract:
- The requester must drop its request in the cycle after *_done, unless it is issuing a new transaction.

Ignored inputs:
- mem_data_valid in IDLE, WRITE or DONE: ignored, no fill_valid.
- Request changes while granted: ignored.

## Timing
- Reset: all outputs are 0, FSM goes to IDLE, counters are 0, pointer is "I".
- Reset mid-transaction aborts it with no *_done. Stale mem_data_valid pulses after reset are ignored.
- Request sampled high at edge N: grant is high from cycle N+1.
- Fill issue: mem_en is high for cycles N+1..N+8.
- Fill completion: DONE is the cycle after the 8th valid. With 4-cycle DRAM latency, valids arrive in cycles N+5..N+12 and DONE is N+13.
- Write: WRITE in cycle N+1, DONE in cycle N+2.
- Minimum gap: one IDLE cycle between DONE and the next grant.
- mem_addr, mem_en, mem_wr and mem_wdata are registered outputs, aligned with the state.
- *_fill_valid, fill_word and fill_data are combinational from mem_data_valid and mem_data.

## Configuration
- **ARB_DPRIORITY_EN defined:** fixed priority. D wins every simultaneous request; the pointer is unused.
- **ARB_DPRIORITY_EN undefined:** round-robin as described in Operation.

## Test plan
- **Single I-fill:** i_req=1, i_addr=0x1236, 4-cycle DRAM.
  - mem_addr = 0x1230, 0x1232, …, 0x123E in cycles 1–8.
  - i_fill_valid in cycles 5–12 with fill_word 0..7.
  - i_done in cycle 13; d_grant never asserts.
- **D write-through:** d_req=1, d_wr=1, d_addr=0x0402, d_wdata=0xBEEF.
  - Cycle 1: mem_en=1, mem_wr=1, mem_addr=0x0402, mem_wdata=0xBEEF.
  - Cycle 2: d_done=1.
- **Simultaneous requests, held:** i_req and d_req both high and held (I requester re-requests after its done).
  - Grants alternate D, I, D; each done is followed by one IDLE cycle.
  - With ARB_DPRIORITY_EN: D is granted every time.
- **Contention during a fill:** i_req rises while a D fill is in progress.
  - No grant change and no I-side fill_valid until after d_done.
  - I is then granted after one IDLE cycle.
- **Reset mid-fill:** rst_n=0 after the 3rd returned word.
  - Next cycle: all outputs 0, no done pulse.
  - Later mem_data_valid pulses produce no fill_valid.
- **Spurious valid:** mem_data_valid=1 while in IDLE.
  - No fill_valid and no state change.
